seg_scroll_ctrl: RTL and testbench



---
 rtl/seg_scroll_ctrl_pkg.sv | 55 +++++
 rtl/seg_scroll_ctrl_if.sv | 33 +++
 rtl/seg_scroll_ctrl_hex7seg_lut.sv | 16 +
 rtl/seg_scroll_ctrl.sv | 166 ++++++++++++++++
 tb/tb_seg_scroll_ctrl.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg_scroll_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// seg_scroll_pkg
// Shared definitions for the seven-segment scroll controller:
//   - scroll FSM state encoding
//   - Avalon register addresses and CTRL / STATUS bit positions
//   - glyph constants and the hex-to-seven-segment encoder
// Segment vectors are active-low with bit0 = a .. bit6 = g.
// ---------------------------------------------------------------------------
package seg_scroll_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam logic [1:0] ADDR_MSG    = 2'd0;
    localparam logic [1:0] ADDR_CTRL   = 2'd1;
    localparam logic [1:0] ADDR_RATE   = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int CTRL_SCROLL_EN = 0;
    localparam int CTRL_BLANK     = 1;
    localparam int CTRL_DIR       = 2;
    localparam int CTRL_W         = 3;

    localparam int STATUS_PAUSED  = 8;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_RESET = 7'h40;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        logic [6:0] seg;
        case (hex)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg_scroll_ctrl_if.sv
// ---------------------------------------------------------------------------
// seg_scroll_ctrl_if
// Avalon-MM register bus of the scroll controller.
//   avs_address   [1:0]  register select
//   avs_write            write strobe
//   avs_writedata [31:0] write data
//   avs_read             read strobe
//   avs_readdata  [31:0] read data, valid the cycle after avs_read
// master: the HPS bridge side; slave: the controller.
// ---------------------------------------------------------------------------
interface seg_scroll_ctrl_if;
    logic [1:0]  avs_address;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        avs_read;
    logic [31:0] avs_readdata;

    modport master (
        output avs_address,
        output avs_write,
        output avs_writedata,
        output avs_read,
        input  avs_readdata
    );

    modport slave (
        input  avs_address,
        input  avs_write,
        input  avs_writedata,
        input  avs_read,
        output avs_readdata
    );
endinterface

// File: rtl/seg_scroll_ctrl_hex7seg_lut.sv
// ---------------------------------------------------------------------------
// hex7seg_lut
// Combinational hex digit to active-low seven-segment decoder.
//   i_hex [3:0]  hex digit
//   o_seg [6:0]  segments, bit0 = a .. bit6 = g, active-low
// ---------------------------------------------------------------------------
module hex7seg_lut
    import seg_scroll_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);

    assign o_seg = hex_to_seg(i_hex);

endmodule

// File: rtl/seg_scroll_ctrl.sv
// ---------------------------------------------------------------------------
// seg_scroll_ctrl
// Avalon-MM slave that scrolls an 8-digit hex message across four
// seven-segment displays at a programmable rate, with pushbutton pause.
//   clk, reset         clock, synchronous active-high reset
//   avs                Avalon-MM slave (MSG, CTRL, RATE, STATUS registers)
//   key_pause_n        pause/resume pushbutton, active-low, asynchronous
//   segment0..3_conduit displays, segment0 rightmost, active-low glyphs
//   step_pulse         one-cycle pulse following each scroll step
// ---------------------------------------------------------------------------
module seg_scroll_ctrl
    import seg_scroll_pkg::*;
#(
    parameter int DIV_W        = 26,
    parameter int DEFAULT_RATE = 49999999,
    parameter int NDIG         = 8
) (
    input  logic              clk,
    input  logic              reset,
    seg_scroll_ctrl_if.slave  avs,
    input  logic              key_pause_n,
    output logic [6:0]        segment0_conduit,
    output logic [6:0]        segment1_conduit,
    output logic [6:0]        segment2_conduit,
    output logic [6:0]        segment3_conduit,
    output logic              step_pulse
);

    localparam int POS_W = $clog2(NDIG);

    logic [31:0]       r_msg;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DIV_W-1:0]  r_rate;
    logic [DIV_W-1:0]  r_presc;
    logic [POS_W-1:0]  r_pos;
    state_t            r_state;
    logic [31:0]       r_readdata;
    logic              r_step_pulse;
    logic [6:0]        r_seg [4];
    logic              r_key_s1;
    logic              r_key_s2;
    logic              r_key_prev;

    logic              w_wr_msg;
    logic              w_wr_ctrl;
    logic              w_wr_rate;
    logic              w_pos_clr;
    logic              w_pause_evt;
    logic              w_step;
    logic [31:0]       w_rdata;
    logic [POS_W-1:0]  w_idx [4];
    logic [3:0]        w_nib [4];
    logic [6:0]        w_seg [4];

    assign w_wr_msg  = avs.avs_write && (avs.avs_address == ADDR_MSG);
    assign w_wr_ctrl = avs.avs_write && (avs.avs_address == ADDR_CTRL);
    assign w_wr_rate = avs.avs_write && (avs.avs_address == ADDR_RATE);
    assign w_pos_clr = avs.avs_write && (avs.avs_address == ADDR_STATUS)
                       && avs.avs_writedata[0];

    // Falling edge of the synchronized button, one cycle wide.
    assign w_pause_evt = r_key_prev && !r_key_s2;

    // A step is the prescaler terminal count while running.
    assign w_step = (r_state == ST_RUN) && (r_presc == r_rate);

    always_comb begin
        w_rdata = '0;
        case (avs.avs_address)
            ADDR_MSG:    w_rdata = r_msg;
            ADDR_CTRL:   w_rdata[CTRL_W-1:0] = r_ctrl;
            ADDR_RATE:   w_rdata[DIV_W-1:0] = r_rate;
            default: begin
                w_rdata[POS_W-1:0]    = r_pos;
                w_rdata[STATUS_PAUSED] = (r_state == ST_PAUSE);
            end
        endcase
    end

    // Register file, read port and button synchronizer.
    // Synchronizer resets to the released level so reset never fakes a press.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_msg      <= '0;
            r_ctrl     <= '0;
            r_rate     <= DIV_W'(DEFAULT_RATE);
            r_readdata <= '0;
            r_key_s1   <= 1'b1;
            r_key_s2   <= 1'b1;
            r_key_prev <= 1'b1;
        end else begin
            r_key_s1   <= key_pause_n;
            r_key_s2   <= r_key_s1;
            r_key_prev <= r_key_s2;
            if (w_wr_msg)  r_msg  <= avs.avs_writedata;
            if (w_wr_ctrl) r_ctrl <= avs.avs_writedata[CTRL_W-1:0];
            if (w_wr_rate) r_rate <= avs.avs_writedata[DIV_W-1:0];
            if (avs.avs_read) r_readdata <= w_rdata;
        end
    end

    // Scroll FSM with prescaler and position. A pause event on a step
    // cycle still lets the step land because w_step is sampled in RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_presc      <= '0;
            r_pos        <= '0;
            r_step_pulse <= 1'b0;
        end else begin
            r_step_pulse <= w_step;

            case (r_state)
                ST_IDLE: begin
                    if (r_ctrl[CTRL_SCROLL_EN]) r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (!r_ctrl[CTRL_SCROLL_EN]) r_state <= ST_IDLE;
                    else if (w_pause_evt)        r_state <= ST_PAUSE;
                end
                ST_PAUSE: begin
                    if (!r_ctrl[CTRL_SCROLL_EN]) r_state <= ST_IDLE;
                    else if (w_pause_evt)        r_state <= ST_RUN;
                end
                default: r_state <= ST_IDLE;
            endcase

            // RATE write restarts the count; otherwise count in RUN,
            // hold in PAUSE, clear in IDLE.
            if (w_wr_rate || r_state == ST_IDLE || w_step) r_presc <= '0;
            else if (r_state == ST_RUN)                    r_presc <= r_presc + DIV_W'(1);

            // NDIG is a power of two, so the natural wrap is modulo NDIG.
            if (w_pos_clr)                r_pos <= '0;
            else if (w_step && r_ctrl[CTRL_DIR]) r_pos <= r_pos - POS_W'(1);
            else if (w_step)              r_pos <= r_pos + POS_W'(1);
        end
    end

    // Display k (from the left) shows message digit pos+k.
    for (genvar k = 0; k < 4; k++) begin : g_digit
        assign w_idx[k] = r_pos + POS_W'(k);
        assign w_nib[k] = r_msg[{w_idx[k], 2'b00} +: 4];
        hex7seg_lut u_lut (
            .i_hex (w_nib[k]),
            .o_seg (w_seg[3-k])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 4; k++) r_seg[k] <= SEG_RESET;
        end else begin
            for (int k = 0; k < 4; k++)
                r_seg[k] <= r_ctrl[CTRL_BLANK] ? SEG_BLANK : w_seg[k];
        end
    end

    assign segment0_conduit = r_seg[0];
    assign segment1_conduit = r_seg[1];
    assign segment2_conduit = r_seg[2];
    assign segment3_conduit = r_seg[3];
    assign step_pulse       = r_step_pulse;
    assign avs.avs_readdata = r_readdata;

endmodule

// File: tb/tb_seg_scroll_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg_scroll_ctrl
// Directed bench for seg_scroll_ctrl. Expected values are pushed to a
// scoreboard queue as stimulus is issued and popped when the DUT output
// is sampled (on the falling clock edge).
// ---------------------------------------------------------------------------
module tb_seg_scroll_ctrl;

    localparam int DEF_RATE = 49999999;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       key_pause_n = 1'b1;
    logic [6:0] seg0, seg1, seg2, seg3;
    logic       step_pulse;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    seg_scroll_ctrl_if bus ();

    seg_scroll_ctrl #(
        .DIV_W        (26),
        .DEFAULT_RATE (DEF_RATE),
        .NDIG         (8)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .avs              (bus),
        .key_pause_n      (key_pause_n),
        .segment0_conduit (seg0),
        .segment1_conduit (seg1),
        .segment2_conduit (seg2),
        .segment3_conduit (seg3),
        .step_pulse       (step_pulse)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [6:0] seg_ref(input logic [3:0] d);
        logic [6:0] t [16];
        t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return t[d];
    endfunction

    // {seg3, seg2, seg1, seg0} for message m at position p.
    function automatic logic [31:0] disp_exp(input logic [31:0] m, input int p);
        logic [31:0] r;
        int          d;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            d = (p + k) % 8;
            r[(3-k)*7 +: 7] = seg_ref(m[d*4 +: 4]);
        end
        return r;
    endfunction

    function automatic logic [31:0] segs_now();
        return {4'b0, seg3, seg2, seg1, seg0};
    endfunction

    task automatic expect_val(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic compare_next(input logic [31:0] obs);
        exp_t e;
        n_assert++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        expect_val(tag, exp);
        compare_next(obs);
    endtask

    // Called at a falling edge; the write is sampled on the next rising edge.
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.avs_address   = a;
        bus.avs_writedata = d;
        bus.avs_write     = 1'b1;
        @(negedge clk);
        bus.avs_write     = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
        expect_val(tag, exp);
        bus.avs_address = a;
        bus.avs_read    = 1'b1;
        @(negedge clk);
        bus.avs_read    = 1'b0;
        compare_next(bus.avs_readdata);
    endtask

    // Waits for the next step pulse; returns the falling edges waited (0 = none).
    task automatic wait_step(input string tag, output int cyc);
        cyc = 0;
        for (int i = 1; i <= 64; i++) begin
            @(negedge clk);
            if (step_pulse) begin
                cyc = i;
                break;
            end
        end
        chk(tag, 32'(cyc != 0), 32'd1);
    endtask

    logic [31:0] msg;
    int          c;
    int          got;
    int          found_i;
    logic [31:0] fpos;
    int          pulses;

    initial begin
        bus.avs_address   = '0;
        bus.avs_write     = 1'b0;
        bus.avs_writedata = '0;
        bus.avs_read      = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_segs", segs_now(), {4'b0, 7'h40, 7'h40, 7'h40, 7'h40});
        chk("rst_step_pulse", 32'(step_pulse), 32'd0);
        chk("rst_readdata", bus.avs_readdata, 32'd0);
        reset = 1'b0;
        rd(2'd0, 32'd0, "rst_msg");
        rd(2'd1, 32'd0, "rst_ctrl");
        rd(2'd2, 32'(DEF_RATE), "rst_rate");
        rd(2'd3, 32'd0, "rst_status");

        // Message load while stopped
        msg = 32'h76543210;
        wr(2'd0, msg);
        @(negedge clk);
        chk("msg_display", segs_now(), disp_exp(msg, 0));
        rd(2'd0, msg, "msg_readback");

        // Forward scroll, RATE=3
        wr(2'd2, 32'd3);
        wr(2'd1, 32'd1);
        wait_step("fwd_step1_seen", c);
        @(negedge clk);
        chk("fwd_step1_display", segs_now(), disp_exp(msg, 1));
        chk("step_pulse_one_cycle", 32'(step_pulse), 32'd0);
        wait_step("fwd_step2_seen", c);
        for (int s = 3; s <= 8; s++) begin
            wait_step("fwd_step_seen", c);
            chk("fwd_step_interval", 32'(c), 32'd4);
        end
        rd(2'd3, 32'd0, "fwd_pos_wrap");

        // Reverse scroll, RATE=0: pos 0,7,6,5 on consecutive cycles
        wr(2'd1, 32'd0);
        wr(2'd3, 32'd1);
        rd(2'd3, 32'd0, "pos_cleared");
        wr(2'd2, 32'd0);
        wr(2'd1, 32'd5);
        expect_val("rev_pos_a", 32'd7);
        expect_val("rev_pos_b", 32'd6);
        expect_val("rev_pos_c", 32'd5);
        bus.avs_address = 2'd3;
        bus.avs_read    = 1'b1;
        got = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (got < 3 && (got > 0 || bus.avs_readdata[2:0] != 3'd0)) begin
                compare_next(32'(bus.avs_readdata[2:0]));
                got++;
            end
        end
        bus.avs_read = 1'b0;
        while (sb.size() > 0) compare_next(32'hFFFF_FFFF);

        // Pause / resume, RATE=7
        wr(2'd1, 32'd0);
        wr(2'd3, 32'd1);
        wr(2'd2, 32'd7);
        wr(2'd1, 32'd1);
        wait_step("pause_pre_step", c);
        key_pause_n     = 1'b0;
        bus.avs_address = 2'd3;
        bus.avs_read    = 1'b1;
        found_i = 0;
        fpos    = '0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 3) key_pause_n = 1'b1;
            if (found_i == 0 && bus.avs_readdata[8]) begin
                found_i = i;
                fpos    = 32'(bus.avs_readdata[2:0]);
            end
        end
        bus.avs_read = 1'b0;
        chk("pause_seen_in_time", 32'(found_i >= 3 && found_i <= 5), 32'd1);
        chk("pause_pos", fpos, 32'd1);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (step_pulse) pulses++;
        end
        chk("no_step_while_paused", 32'(pulses), 32'd0);
        rd(2'd3, 32'h101, "paused_status");

        // Resume: 3 counts were spent before the pause took hold and the
        // FSM returns to RUN 3 edges after the press, so the next step is
        // RATE+1 = 8 falling edges after the press.
        key_pause_n = 1'b0;
        c = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 3) key_pause_n = 1'b1;
            if (step_pulse && c == 0) c = i;
        end
        chk("resume_step_latency", 32'(c), 32'd8);
        rd(2'd3, 32'h003, "resume_status");

        // Clear of pos on the same edge as a step, RATE=3
        wr(2'd2, 32'd3);
        wait_step("clr_sync_step", c);
        repeat (3) @(negedge clk);
        wr(2'd3, 32'd1);
        chk("clr_coincides_with_step", 32'(step_pulse), 32'd1);
        rd(2'd3, 32'd0, "clr_wins");

        // Blank keeps scrolling
        wr(2'd1, 32'd3);
        wait_step("blank_step1", c);
        chk("blank_segs", segs_now(), {4'b0, 7'h7F, 7'h7F, 7'h7F, 7'h7F});
        rd(2'd3, 32'd1, "blank_pos1");
        wait_step("blank_step2", c);
        rd(2'd3, 32'd2, "blank_pos2");

        // Reset mid-run
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_segs", segs_now(), {4'b0, 7'h40, 7'h40, 7'h40, 7'h40});
        chk("midrst_step_pulse", 32'(step_pulse), 32'd0);
        chk("midrst_readdata", bus.avs_readdata, 32'd0);
        reset = 1'b0;
        rd(2'd0, 32'd0, "midrst_msg");
        rd(2'd2, 32'(DEF_RATE), "midrst_rate");
        rd(2'd3, 32'd0, "midrst_status");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
